// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer: walks a Thumb PUSH/POP register list one transfer per
// cycle, then issues a single SP write-back beat. Freezes fetch/decode while
// a sequence runs and honours a downstream hold on every beat.
module reg_list_sequencer #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD       = 32,
    parameter int LIST_WIDTH = 8,
    parameter int LR_ADDR    = 14,
    parameter int PC_ADDR    = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  is_pop_i,
    input  logic [LIST_WIDTH-1:0] reg_list_i,
    input  logic                  extra_reg_i,
    input  logic                  hold_i,
    output logic                  stall_pipeline_o,
    output logic                  xfer_valid_o,
    output logic                  xfer_is_pop_o,
    output logic [ADDR_WIDTH-1:0] xfer_reg_addr_o,
    output logic [WORD-1:0]       xfer_offset_o,
    output logic                  sp_update_o,
    output logic [WORD-1:0]       sp_delta_o,
    output logic                  done_o,
    output logic                  busy_o
);

    // Extended list carries the LR/PC request as its top bit so it is
    // naturally visited last by the lowest-set-bit scan.
    localparam int LW1 = LIST_WIDTH + 1;
    localparam int CW  = $clog2(LIST_WIDTH + 2);
    localparam int IW  = $clog2(LW1);

    typedef enum logic [1:0] {IDLE, ISSUE, SP_UPD} state_t;

    state_t         state_q, state_d;
    logic           pop_q, pop_d;
    logic [LW1-1:0] list_q, list_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  idx_q, idx_d;

    logic [CW-1:0]  start_cnt;
    logic [IW-1:0]  sel;
    logic [LW1-1:0] remain;
    logic [WORD-1:0] idx4, cnt4;

    // Popcount of the incoming list plus the optional extra register.
    always_comb begin
        start_cnt = CW'(extra_reg_i);
        for (int k = 0; k < LIST_WIDTH; k++)
            start_cnt = start_cnt + CW'(reg_list_i[k]);
    end

    // Lowest set bit of the remaining list, and the list with it removed.
    always_comb begin
        sel = '0;
        for (int k = LW1 - 1; k >= 0; k--)
            if (list_q[k]) sel = IW'(k);
        remain = list_q & ~(LW1'(1) << sel);
    end

    // Next-state logic and the start_i -> stall combinational path.
    always_comb begin
        state_d          = state_q;
        pop_d            = pop_q;
        list_d           = list_q;
        cnt_d            = cnt_q;
        idx_d            = idx_q;
        stall_pipeline_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_pipeline_o = start_i;
                if (start_i) begin
                    pop_d   = is_pop_i;
                    list_d  = {extra_reg_i, reg_list_i};
                    cnt_d   = start_cnt;
                    idx_d   = '0;
                    state_d = (start_cnt == '0) ? SP_UPD : ISSUE;
                end
            end
            ISSUE: begin
                stall_pipeline_o = 1'b1;
                if (!hold_i) begin
                    list_d = remain;
                    idx_d  = idx_q + CW'(1);
                    if (remain == '0) state_d = SP_UPD;
                end
            end
            SP_UPD: begin
                // Released on the accepted beat so decode resumes on return to IDLE.
                stall_pipeline_o = hold_i;
                if (!hold_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any sequence without an SP beat.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pop_q   <= 1'b0;
            list_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pop_q   <= pop_d;
            list_q  <= list_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Beat outputs decoded from registered state only.
    always_comb begin
        idx4            = WORD'({idx_q, 2'b00});
        cnt4            = WORD'({cnt_q, 2'b00});
        xfer_valid_o    = (state_q == ISSUE);
        xfer_is_pop_o   = xfer_valid_o & pop_q;
        xfer_reg_addr_o = '0;
        xfer_offset_o   = '0;
        if (xfer_valid_o) begin
            if (sel == IW'(LIST_WIDTH))
                xfer_reg_addr_o = pop_q ? ADDR_WIDTH'(PC_ADDR) : ADDR_WIDTH'(LR_ADDR);
            else
                xfer_reg_addr_o = ADDR_WIDTH'(sel);
            // PUSH stores the lowest register at SP-4*count.
            xfer_offset_o = pop_q ? idx4 : (idx4 - cnt4);
        end
        sp_update_o = (state_q == SP_UPD);
        sp_delta_o  = sp_update_o ? (pop_q ? cnt4 : (~cnt4 + WORD'(1))) : '0;
        done_o      = sp_update_o;
        busy_o      = (state_q != IDLE);
    end

endmodule
